pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. It splits a WIDTH-bit operation into WIDTH/BLOCK lookahead blocks, one per pipeline stage, and registers the block carry between stages. A valid/ready handshake with full backpressure lets it sit between the operand-fetch and writeback stages. It replaces the single-cycle 8-bit lookahead block wherever wide operands would break the clock period.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of BLOCK, at least BLOCK
- BLOCK, 8, bits resolved per stage by full lookahead (p/g carry equations); STAGES = WIDTH/BLOCK
- clock  input  1  rising-edge clock, the only clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts the beat this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- sub  input  1  1: x − y (y inverted, carry-in 1); 0: x + y + c_in
- c_in  input  1  carry-in, used only when sub=0
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result
- s  output  WIDTH  sum/difference
- c_out  output  1  carry out of MSB (for sub: 1 means no borrow)
- overflow  output  1  signed overflow (see Configuration)
- zero  output  1  s == 0 (see Configuration)

## Operation
- Stage k (0..STAGES−1) computes bits [k·BLOCK +: BLOCK] with p = a^b, g = a&b, carry lookahead from the registered carry of stage k−1. Stage 0 uses carry-in = sub ? 1 : c_in.
- Effective b = sub ? ~y : y, formed before stage 0 and carried forward.
- Each stage register holds: valid bit, carry out of its block, lower result bits done so far, and the unconsumed upper operand slices.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. When adv=1, every stage register loads from its predecessor, valid bits included. When adv=0, every stage register holds.
- Bubbles are not compacted. An empty stage shifts like a full one.
- Accept occurs on in_valid && in_ready. A beat offered with in_ready=0 is ignored, and the source must hold it.
- Output registers s, c_out, overflow and zero are the final stage's contents. They stay stable while out_valid && !out_ready.
- STAGES=1 degenerates to a registered single-block adder with the same handshake.

## Timing
- Reset (asynchronous, reset_n=0): all valid bits 0, out_valid=0, s=0, c_out=0, overflow=0, zero=0. in_ready is 1 while out_valid=0.
- Reset asserted mid-operation discards all in-flight beats immediately. The first accept is possible on the first rising edge after deassertion.
- Latency: a beat accepted at edge N presents out_valid=1 after edge N+STAGES−1 when there are no stalls, i.e. STAGES register stages.
- Throughput: one result per cycle with out_ready held 1.
- Stall: each cycle with out_valid=1 and out_ready=0 adds exactly one cycle to every in-flight beat. No beat is dropped or duplicated.
- Simultaneous events: when out_valid && out_ready && in_valid in the same cycle, the output is consumed, the pipeline shifts and the new beat is accepted.
- in_ready is combinational from out_valid and out_ready only, never from in_valid.

## Configuration
- PCLA_FLAGS_EN defined:
  - overflow = (a_msb == b_eff_msb) && (s_msb != a_msb), computed in the final stage.
  - zero = (s == 0), computed in the final stage.
  - Both are registered alongside s.
- PCLA_FLAGS_EN undefined:
  - overflow and zero are tied to 0.
  - No flag logic or registers are generated.
  - Latency and handshake are unchanged.

## Test plan
- WIDTH=32, BLOCK=8, flags on. Stimulus: x=0xFFFFFFFF, y=0x00000001, sub=0, c_in=0. Response after 4 cycles: s=0, c_out=1, overflow=0, zero=1. This exercises a carry rippling through every stage.
- Stimulus: x=0x7FFFFFFF, y=1, sub=0. Response: s=0x80000000, c_out=0, overflow=1. Stimulus: x=5, y=7, sub=1. Response: s=0xFFFFFFFE, c_out=0, overflow=0, zero=0.
- Stream 100 random beats with out_ready=1. Required: out_valid continuous from cycle 4, results in order and matching the reference model.
- Backpressure: drop out_ready for 3 cycles with a full pipeline. Required: in_ready=0 during the stall, s held constant, no loss or duplicate after release. Repeat with random in_valid and out_ready.
- Assert reset_n=0 with 3 beats in flight. Required: out_valid=0 and all outputs 0 asynchronously, and none of the discarded beats appear after release.
- Configuration and parameter variants:
  - Flags off: overflow=zero=0 for the 0x7FFFFFFF+1 case.
  - WIDTH=16, BLOCK=16: latency 1.
  - WIDTH=64, BLOCK=8: latency 8, 0xFFFF…F + 1 gives s=0, c_out=1.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit add/sub, one BLOCK-bit lookahead block per stage.
// Define PCLA_FLAGS_EN to generate the overflow and zero flags.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / BLOCK;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // The whole pipe moves together; only a stalled output freezes it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~y : y;
  assign c0       = sub | c_in;

  // Each carry is a flat sum of products of p/g terms and the block carry-in.
  function automatic logic [BLOCK:0] cla_carries(
    input logic [BLOCK-1:0] p,
    input logic [BLOCK-1:0] g,
    input logic             ci
  );
    logic [BLOCK:0] c;
    logic           t;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      t = ci;
      for (int j = 0; j <= i; j++) begin
        t = t & p[j];
      end
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) begin
          t = t & p[m];
        end
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * BLOCK;
    localparam int HI = LO + BLOCK;
    // operand bits this stage still has to consume
    localparam int RW = WIDTH - LO;

    logic [RW-1:0]    a_src;
    logic [RW-1:0]    b_src;
    logic             v_src;
    logic             c_src;
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] sum;
    logic [BLOCK:0]   cc;
    logic [HI-1:0]    r_nxt;
    logic [HI-1:0]    r_q;
    logic             v_q;
    logic             c_q;

    if (k == 0) begin : g_head
      assign a_src = x;
      assign b_src = b_eff;
      assign v_src = in_valid;
      assign c_src = c0;
      assign r_nxt = sum;
    end else begin : g_body
      assign a_src = g_st[k-1].g_up.a_q;
      assign b_src = g_st[k-1].g_up.b_q;
      assign v_src = g_st[k-1].v_q;
      assign c_src = g_st[k-1].c_q;
      assign r_nxt = {sum, g_st[k-1].r_q};
    end

    assign p   = a_src[BLOCK-1:0] ^ b_src[BLOCK-1:0];
    assign g   = a_src[BLOCK-1:0] & b_src[BLOCK-1:0];
    assign cc  = cla_carries(p, g, c_src);
    assign sum = p ^ cc[BLOCK-1:0];

    // Stage register: valid, block carry and result so far.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (adv) begin
        v_q <= v_src;
        c_q <= cc[BLOCK];
        r_q <= r_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_up
      logic [RW-BLOCK-1:0] a_q;
      logic [RW-BLOCK-1:0] b_q;

      // Carry the unconsumed operand slices forward.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_src[RW-1:BLOCK];
          b_q <= b_src[RW-1:BLOCK];
        end
      end
    end else begin : g_tail
      assign out_valid = v_q;
      assign s         = r_q;
      assign c_out     = c_q;
`ifdef PCLA_FLAGS_EN
      logic ov_q;
      logic z_q;

      // Flags come from the MSB block and the full result.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          ov_q <= 1'b0;
          z_q  <= 1'b0;
        end else if (adv) begin
          ov_q <= (a_src[BLOCK-1] == b_src[BLOCK-1]) &&
                  (sum[BLOCK-1] != a_src[BLOCK-1]);
          z_q  <= (r_nxt == '0);
        end
      end

      assign overflow = ov_q;
      assign zero     = z_q;
`else
      assign overflow = 1'b0;
      assign zero     = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: vectors, random streaming, stalls, reset.
// Flag expectations follow PCLA_FLAGS_EN.
module tb_pipelined_cla_adder;

`ifdef PCLA_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        ov;
    logic        z;
  } res_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        sub;
    logic        cin;
    logic [31:0] s;
    logic        c;
    logic        ov;
    logic        z;
  } vec_t;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        sub;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        c_out;
  logic        overflow;
  logic        zero;

  logic        iv64, ir64, ov64, co64, of64, z64;
  logic [63:0] x64, y64, s64;
  logic        iv16, ir16, ov16, co16, of16, z16;
  logic [15:0] x16, y16, s16;

  int          checks;
  int          errors;
  int          n_out;
  res_t        model[$];
  logic        stalled_prev;
  logic [31:0] held_s;
  logic        acc;
  vec_t        vt[9];

  pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sub(sub), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .overflow(overflow), .zero(zero)
  );

  pipelined_cla_adder #(.WIDTH(64), .BLOCK(8)) dut64 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(iv64), .in_ready(ir64),
    .x(x64), .y(y64), .sub(1'b0), .c_in(1'b0),
    .out_valid(ov64), .out_ready(1'b1),
    .s(s64), .c_out(co64), .overflow(of64), .zero(z64)
  );

  pipelined_cla_adder #(.WIDTH(16), .BLOCK(16)) dut16 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(iv16), .in_ready(ir16),
    .x(x16), .y(y16), .sub(1'b0), .c_in(1'b0),
    .out_valid(ov16), .out_ready(1'b1),
    .s(s16), .c_out(co16), .overflow(of16), .zero(z16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  // Reference: plain wide arithmetic on the effective operands.
  function automatic res_t ref_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sb,
    input logic        ci
  );
    res_t        r;
    logic [31:0] be;
    longint      c0, u, sg;
    be   = sb ? ~b : b;
    c0   = (sb || ci) ? 64'sd1 : 64'sd0;
    u    = longint'({32'd0, a}) + longint'({32'd0, be}) + c0;
    sg   = longint'(signed'(a)) + longint'(signed'(be)) + c0;
    r.s  = u[31:0];
    r.c  = u[32];
    r.ov = FL && (sg != longint'(signed'(u[31:0])));
    r.z  = FL && (u[31:0] == 32'd0);
    return r;
  endfunction

  task automatic cycle(
    input logic        iv,
    input logic [31:0] xa,
    input logic [31:0] ya,
    input logic        sb,
    input logic        ci,
    input logic        ordy
  );
    res_t e;
    @(negedge clock);
    in_valid  = iv;
    x         = xa;
    y         = ya;
    sub       = sb;
    c_in      = ci;
    out_ready = ordy;
    #1;
    if (stalled_prev) begin
      checks++;
      if (out_valid !== 1'b1 || s !== held_s) begin
        errors++;
        $display("FAIL stall_hold: out_valid=%b s=%h, required 1 %h",
                 out_valid, s, held_s);
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b0) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready: in_ready=%b, required 0", in_ready);
      end
    end
    if (out_valid === 1'b0) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_ready: in_ready=%b, required 1", in_ready);
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_out++;
      checks++;
      if (model.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: s=%h, required no output", s);
      end else begin
        e = model.pop_front();
        if ({s, c_out, overflow, zero} !== e) begin
          errors++;
          $display("FAIL result: s=%h c=%b ov=%b z=%b, required %h %b %b %b",
                   s, c_out, overflow, zero, e.s, e.c, e.ov, e.z);
        end
      end
    end
    acc = in_valid && in_ready;
    if (acc) model.push_back(ref_add(x, y, sub, c_in));
    stalled_prev = out_valid && !out_ready;
    held_s       = s;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (model.size() == 0 && out_valid !== 1'b1) break;
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (model.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats missing, required 0", model.size());
    end
  endtask

  initial begin
    int   lat;
    int   lat64;
    int   lat16;
    int   n_before;
    logic pv;
    logic [31:0] bx, by;
    logic bs, bc;

    vt[0] = '{32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
    vt[1] = '{32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[2] = '{32'h5, 32'h7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vt[3] = '{32'h7, 32'h5, 1'b1, 1'b0, 32'h2, 1'b1, 1'b0, 1'b0};
    vt[4] = '{32'h80000000, 32'h1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vt[5] = '{32'h0, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{32'h5, 32'h5, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1};
    vt[7] = '{32'h0000FF00, 32'h100, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vt[8] = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0};

    checks = 0;
    errors = 0;
    n_out = 0;
    stalled_prev = 1'b0;
    held_s = '0;
    acc = 1'b0;
    reset_n = 1'b1;
    in_valid = 1'b0;
    x = '0;
    y = '0;
    sub = 1'b0;
    c_in = 1'b0;
    out_ready = 1'b1;
    iv64 = 1'b0;
    x64 = '0;
    y64 = '0;
    iv16 = 1'b0;
    x16 = '0;
    y16 = '0;

    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, s, c_out, overflow, zero, in_ready} !== {1'b0, 32'd0, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: v=%b s=%h c=%b ov=%b z=%b rdy=%b, required 0 0 0 0 0 1",
               out_valid, s, c_out, overflow, zero, in_ready);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      cycle(1'b1, vt[i].x, vt[i].y, vt[i].sub, vt[i].cin, 1'b1);
      lat = 0;
      for (int j = 1; j <= 20; j++) begin
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        if (out_valid === 1'b1) begin
          lat = j;
          break;
        end
      end
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL latency vec%0d: %0d cycles, required 4", i, lat);
      end
      checks++;
      if ({s, c_out, overflow, zero} !==
          {vt[i].s, vt[i].c, vt[i].ov & FL, vt[i].z & FL}) begin
        errors++;
        $display("FAIL vec%0d: s=%h c=%b ov=%b z=%b, required %h %b %b %b",
                 i, s, c_out, overflow, zero, vt[i].s, vt[i].c,
                 vt[i].ov & FL, vt[i].z & FL);
      end
      drain();
    end

    for (int i = 0; i < 108; i++) begin
      if (i < 100)
        cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1);
      else
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== (i >= 4 && i < 104)) begin
        errors++;
        $display("FAIL stream_valid call%0d: out_valid=%b, required %b",
                 i, out_valid, (i >= 4 && i < 104));
      end
    end
    drain();

    for (int i = 0; i < 6; i++)
      cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b1);
    bx = $urandom;
    by = $urandom;
    repeat (3) cycle(1'b1, bx, by, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, bx, by, 1'b1, 1'b0, 1'b1);
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL release_accept: accepted=%b, required 1", acc);
    end
    drain();

    pv = 1'b0;
    bs = 1'b0;
    bc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pv && $urandom_range(0, 2) != 0) begin
        pv = 1'b1;
        bx = $urandom;
        by = $urandom;
        bs = 1'($urandom_range(0, 1));
        bc = 1'($urandom_range(0, 1));
      end
      cycle(pv, bx, by, bs, bc, ($urandom_range(0, 3) != 0));
      if (acc) pv = 1'b0;
    end
    drain();

    for (int i = 0; i < 6; i++)
      cycle(1'b1, $urandom | 32'h1, $urandom, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: out_valid=%b, required 1", out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, s, c_out, overflow, zero, in_ready} !== {1'b0, 32'd0, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: v=%b s=%h c=%b ov=%b z=%b rdy=%b, required 0 0 0 0 0 1",
               out_valid, s, c_out, overflow, zero, in_ready);
    end
    model.delete();
    stalled_prev = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    n_before = n_out;
    repeat (12) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (n_out != n_before) begin
      errors++;
      $display("FAIL ghost_beats: %0d outputs after reset, required 0",
               n_out - n_before);
    end

    @(negedge clock);
    checks++;
    if ({ir64, ir16} !== 2'b11) begin
      errors++;
      $display("FAIL variant_ready: %b%b, required 11", ir64, ir16);
    end
    iv64 = 1'b1;
    x64 = '1;
    y64 = 64'd1;
    iv16 = 1'b1;
    x16 = '1;
    y16 = 16'd1;
    lat64 = 0;
    lat16 = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clock);
      iv64 = 1'b0;
      iv16 = 1'b0;
      #1;
      if (lat64 == 0 && ov64 === 1'b1) begin
        lat64 = j;
        checks++;
        if ({s64, co64, of64, z64} !== {64'd0, 1'b1, 1'b0, FL}) begin
          errors++;
          $display("FAIL w64_result: s=%h c=%b ov=%b z=%b, required 0 1 0 %b",
                   s64, co64, of64, z64, FL);
        end
      end
      if (lat16 == 0 && ov16 === 1'b1) begin
        lat16 = j;
        checks++;
        if ({s16, co16, of16, z16} !== {16'd0, 1'b1, 1'b0, FL}) begin
          errors++;
          $display("FAIL w16_result: s=%h c=%b ov=%b z=%b, required 0 1 0 %b",
                   s16, co16, of16, z16, FL);
        end
      end
    end
    checks++;
    if (lat64 != 8) begin
      errors++;
      $display("FAIL w64_latency: %0d, required 8", lat64);
    end
    checks++;
    if (lat16 != 1) begin
      errors++;
      $display("FAIL w16_latency: %0d, required 1", lat16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
